// File: rtl/multi_lane_fifo_if.sv
// Handshake and status bundle for multi_lane_fifo: the producer/consumer side
// drives through the master modport, the FIFO uses the slave modport.
interface multi_lane_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12,
  parameter int PAR_WRITE  = 4,
  parameter int PAR_READ   = 2
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int WN_W      = $clog2(PAR_WRITE + 1);
  localparam int RN_W      = $clog2(PAR_READ + 1);

  logic                            flush;
  logic                            write_enable;
  logic [WN_W-1:0]                 wr_num;
  logic [PAR_WRITE*DATA_WIDTH-1:0] din;
  logic                            read_enable;
  logic [RN_W-1:0]                 rd_num;
  logic [PAR_READ*DATA_WIDTH-1:0]  dout;
  logic                            ready;
  logic                            valid;
  logic [CNT_WIDTH-1:0]            count;
  logic                            almost_full;
  logic                            almost_empty;
  logic                            overflow;
  logic                            underflow;

  modport master (
    output flush, write_enable, wr_num, din, read_enable, rd_num,
    input  dout, ready, valid, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, write_enable, wr_num, din, read_enable, rd_num,
    output dout, ready, valid, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/multi_lane_fifo.sv
// Circular FIFO accepting 0..PAR_WRITE words and releasing 0..PAR_READ words per
// cycle, with show-ahead head lanes, level flags, flush and sticky error flags.
module multi_lane_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12,
  parameter int PAR_WRITE  = 4,
  parameter int PAR_READ   = 2,
  parameter int AF_LEVEL   = DEPTH - PAR_WRITE,
  parameter int AE_LEVEL   = PAR_READ
) (
  input  logic               clk,
  input  logic               rst,
  multi_lane_fifo_if.slave   bus
);
  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   sum_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  // Non-power-of-two depth: wrap by a single conditional subtract of DEPTH.
  function automatic addr_t addr_wrap(input sum_t sum);
    sum_t adj;
    adj = (sum >= sum_t'(DEPTH)) ? (sum - sum_t'(DEPTH)) : sum;
    return adj[ADDR_WIDTH-1:0];
  endfunction

  function automatic addr_t addr_add(input addr_t base, input sum_t offs);
    return addr_wrap({1'b0, base} + offs);
  endfunction

  logic [DATA_WIDTH-1:0]          r_mem [DEPTH];
  addr_t                          r_rptr;
  addr_t                          r_wptr;
  cnt_t                           r_count;
  logic                           r_overflow;
  logic                           r_underflow;

  cnt_t                           w_free;
  cnt_t                           w_wr_cnt;
  cnt_t                           w_rd_cnt;
  sum_t                           w_wr_off;
  sum_t                           w_rd_off;
  logic                           w_wacc;
  logic                           w_racc;
  logic                           w_wrej;
  logic                           w_rrej;
  cnt_t                           w_count_nxt;
  logic [PAR_READ*DATA_WIDTH-1:0] w_dout;

  assign w_free   = cnt_t'(DEPTH) - r_count;
  assign w_wr_cnt = cnt_t'(bus.wr_num);
  assign w_rd_cnt = cnt_t'(bus.rd_num);
  assign w_wr_off = sum_t'(bus.wr_num);
  assign w_rd_off = sum_t'(bus.rd_num);

  // Read and write are judged independently on pre-edge state; a same-cycle
  // read does not make room for the write.
  assign w_wacc = bus.write_enable && (w_wr_cnt <= w_free) && (w_wr_cnt <= cnt_t'(PAR_WRITE));
  assign w_racc = bus.read_enable  && (w_rd_cnt <= r_count) && (w_rd_cnt <= cnt_t'(PAR_READ));
  assign w_wrej = bus.write_enable && (w_wr_cnt != '0) && !w_wacc;
  assign w_rrej = bus.read_enable  && (w_rd_cnt != '0) && !w_racc;

  assign w_count_nxt = r_count + (w_wacc ? w_wr_cnt : '0) - (w_racc ? w_rd_cnt : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wacc) r_wptr <= addr_add(r_wptr, w_wr_off);
      if (w_racc) r_rptr <= addr_add(r_rptr, w_rd_off);
      r_count <= w_count_nxt;
      if (w_wrej) r_overflow  <= 1'b1;
      if (w_rrej) r_underflow <= 1'b1;
    end
  end

  // Storage is never reset; only lanes below wr_num are committed.
  always_ff @(posedge clk) begin
    if (!bus.flush && w_wacc) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        if (cnt_t'(i) < w_wr_cnt)
          r_mem[addr_add(r_wptr, sum_t'(i))] <= bus.din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_dout = '0;
    for (int j = 0; j < PAR_READ; j++) begin
      if (cnt_t'(j) < r_count)
        w_dout[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[addr_add(r_rptr, sum_t'(j))];
    end
  end

  assign bus.dout         = w_dout;
  assign bus.count        = r_count;
  assign bus.ready        = (w_free >= cnt_t'(PAR_WRITE));
  assign bus.valid        = (r_count >= cnt_t'(PAR_READ));
  assign bus.almost_full  = (r_count >= cnt_t'(AF_LEVEL));
  assign bus.almost_empty = (r_count <= cnt_t'(AE_LEVEL));
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_multi_lane_fifo.sv
// Directed bench for multi_lane_fifo (DEPTH=12, PAR_WRITE=4, PAR_READ=2).
module tb_multi_lane_fifo;
  localparam int DW = 8, DEPTH = 12, PW = 4, PR = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_lane_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PAR_WRITE(PW), .PAR_READ(PR)) bus ();

  multi_lane_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PAR_WRITE(PW), .PAR_READ(PR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic drive(input logic we, input logic [2:0] wn, input logic [31:0] d,
                       input logic re, input logic [1:0] rn, input logic fl);
    bus.write_enable = we;
    bus.wr_num       = wn;
    bus.din          = d;
    bus.read_enable  = re;
    bus.rd_num       = rn;
    bus.flush        = fl;
  endtask

  task automatic xfer(input logic we, input logic [2:0] wn, input logic [31:0] d,
                      input logic re, input logic [1:0] rn, input logic fl);
    drive(we, wn, d, re, rn, fl);
    @(posedge clk);
    #1;
    drive(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 1'b0);
    #2;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.valid); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL rst_af got=%b exp=0", bus.almost_full); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae got=%b exp=1", bus.almost_empty); end
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", bus.overflow, bus.underflow); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL rst_dout got=%h exp=0000", bus.dout); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill;
    xfer(1'b1, 3'd4, 32'h03020100, 1'b0, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL fill1_count got=%0d exp=4", bus.count); end
    checks++; if (bus.dout !== 16'h0100) begin errors++; $display("FAIL fill1_dout got=%h exp=0100", bus.dout); end
    checks++; if ({bus.almost_full, bus.almost_empty, bus.valid} !== 3'b001) begin errors++; $display("FAIL fill1_flags got=%b exp=001", {bus.almost_full, bus.almost_empty, bus.valid}); end
    xfer(1'b1, 3'd4, 32'h07060504, 1'b0, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fill2_count got=%0d exp=8", bus.count); end
    checks++; if ({bus.almost_full, bus.ready} !== 2'b11) begin errors++; $display("FAIL fill2_af_ready got=%b exp=11", {bus.almost_full, bus.ready}); end
    xfer(1'b1, 3'd4, 32'h0B0A0908, 1'b0, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd12) begin errors++; $display("FAIL fill3_count got=%0d exp=12", bus.count); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL fill3_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill3_ovf got=%b exp=0", bus.overflow); end
    checks++; if (bus.dout !== 16'h0100) begin errors++; $display("FAIL fill3_dout got=%h exp=0100", bus.dout); end
  endtask

  task automatic test_overflow;
    xfer(1'b1, 3'd1, 32'h000000EE, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd10) begin errors++; $display("FAIL ovf_count got=%0d exp=10", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL ovf_unf got=%b exp=0", bus.underflow); end
    checks++; if (bus.dout !== 16'h0302) begin errors++; $display("FAIL ovf_dout got=%h exp=0302", bus.dout); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got=%b exp=0", bus.ready); end
    xfer(1'b1, 3'd2, 32'h0000BBAA, 1'b0, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd12) begin errors++; $display("FAIL partial_wr_count got=%0d exp=12", bus.count); end
  endtask

  task automatic test_drain_empty;
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.dout !== 16'h0504) begin errors++; $display("FAIL drain1_dout got=%h exp=0504", bus.dout); end
    for (int i = 0; i < 4; i++) xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd2) begin errors++; $display("FAIL drain5_count got=%0d exp=2", bus.count); end
    checks++; if (bus.dout !== 16'hBBAA) begin errors++; $display("FAIL drain5_dout got=%h exp=bbaa", bus.dout); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL empty_count got=%0d exp=0", bus.count); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL empty_dout got=%h exp=0000", bus.dout); end
    checks++; if ({bus.valid, bus.almost_empty} !== 2'b01) begin errors++; $display("FAIL empty_flags got=%b exp=01", {bus.valid, bus.almost_empty}); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd1, 1'b0);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL empty_unf got=%b exp=1", bus.underflow); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL empty_rd_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_flush;
    xfer(1'b1, 3'd4, 32'h44332211, 1'b0, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL preflush_count got=%0d exp=4", bus.count); end
    xfer(1'b1, 3'd4, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b1);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", bus.count); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL flush_dout got=%h exp=0000", bus.dout); end
    checks++; if ({bus.overflow, bus.underflow} !== 2'b11) begin errors++; $display("FAIL flush_sticky got=%b%b exp=11", bus.overflow, bus.underflow); end
    xfer(1'b1, 3'd1, 32'h00000077, 1'b0, 2'd0, 1'b0);
    checks++; if (bus.dout !== 16'h0077) begin errors++; $display("FAIL postflush_dout got=%h exp=0077", bus.dout); end
  endtask

  task automatic test_wrap;
    xfer(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 1'b1);
    xfer(1'b1, 3'd4, 32'h01010101, 1'b0, 2'd0, 1'b0);
    xfer(1'b1, 3'd4, 32'h02020202, 1'b0, 2'd0, 1'b0);
    xfer(1'b1, 3'd2, 32'h00000303, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL wrap_pre_count got=%0d exp=0", bus.count); end
    xfer(1'b1, 3'd4, 32'hD0C0B0A0, 1'b0, 2'd0, 1'b0);
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL wrap_wr_count got=%0d exp=4", bus.count); end
    checks++; if (bus.dout !== 16'hB0A0) begin errors++; $display("FAIL wrap_dout0 got=%h exp=b0a0", bus.dout); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.dout !== 16'hD0C0) begin errors++; $display("FAIL wrap_dout1 got=%h exp=d0c0", bus.dout); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if ({bus.count, bus.dout} !== {4'd0, 16'h0000}) begin errors++; $display("FAIL wrap_end got=%0d/%h exp=0/0000", bus.count, bus.dout); end
  endtask

  task automatic test_async_reset;
    xfer(1'b1, 3'd4, 32'h5A5A5A5A, 1'b0, 2'd0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.dout !== 16'h0000) begin errors++; $display("FAIL arst_dout got=%h exp=0000", bus.dout); end
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL arst_flags got=%b%b exp=00", bus.overflow, bus.underflow); end
    checks++; if ({bus.ready, bus.valid, bus.almost_full, bus.almost_empty} !== 4'b1001) begin errors++; $display("FAIL arst_status got=%b exp=1001", {bus.ready, bus.valid, bus.almost_full, bus.almost_empty}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mixed;
    logic [31:0] d;
    for (int k = 1; k <= 4; k++) begin
      d = {8'd0, 8'(3*k), 8'(3*k-1), 8'(3*k-2)};
      xfer(1'b1, 3'd3, d, 1'b1, 2'd2, 1'b0);
      checks++; if (bus.count !== 4'(k+2)) begin errors++; $display("FAIL mixed_count[%0d] got=%0d exp=%0d", k, bus.count, k+2); end
      checks++; if (bus.dout !== {8'(2*k), 8'(2*k-1)}) begin errors++; $display("FAIL mixed_dout[%0d] got=%h exp=%h", k, bus.dout, {8'(2*k), 8'(2*k-1)}); end
    end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL mixed_unf got=%b exp=1", bus.underflow); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.dout !== 16'h0A09) begin errors++; $display("FAIL mixed_drain1 got=%h exp=0a09", bus.dout); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.dout !== 16'h0C0B) begin errors++; $display("FAIL mixed_drain2 got=%h exp=0c0b", bus.dout); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if ({bus.count, bus.dout} !== {4'd0, 16'h0000}) begin errors++; $display("FAIL mixed_drain3 got=%0d/%h exp=0/0000", bus.count, bus.dout); end
  endtask

  task automatic test_partial_head;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    xfer(1'b1, 3'd0, 32'd0, 1'b1, 2'd0, 1'b0);
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL zero_req_flags got=%b%b exp=00", bus.overflow, bus.underflow); end
    xfer(1'b1, 3'd5, 32'h01020304, 1'b0, 2'd0, 1'b0);
    checks++; if ({bus.overflow, bus.count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL wrnum_big got=%b/%0d exp=1/0", bus.overflow, bus.count); end
    xfer(1'b1, 3'd1, 32'h0000005A, 1'b0, 2'd0, 1'b0);
    checks++; if (bus.dout !== 16'h005A) begin errors++; $display("FAIL head1_dout got=%h exp=005a", bus.dout); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd2, 1'b0);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL head_unf got=%b exp=1", bus.underflow); end
    checks++; if ({bus.count, bus.dout} !== {4'd1, 16'h005A}) begin errors++; $display("FAIL head_hold got=%0d/%h exp=1/005a", bus.count, bus.dout); end
    xfer(1'b0, 3'd0, 32'd0, 1'b1, 2'd1, 1'b0);
    checks++; if ({bus.count, bus.dout} !== {4'd0, 16'h0000}) begin errors++; $display("FAIL head_rd1 got=%0d/%h exp=0/0000", bus.count, bus.dout); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_drain_empty;
    test_flush;
    test_wrap;
    test_async_reset;
    test_mixed;
    test_partial_head;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_lane_fifo.md
# multi_lane_fifo

Parametrised multi-lane circular FIFO: each cycle it accepts a runtime-selected number of words (0..PAR_WRITE) and releases a runtime-selected number of words (0..PAR_READ). It exposes occupancy, programmable almost-full/almost-empty flags, a synchronous flush and sticky overflow/underflow error flags. It replaces the fixed-parallelism FIFO buffer between the stream producers and the window/compute units where per-cycle rates vary.

## Interface

- DATA_WIDTH, 8, bits per word
- DEPTH, 12, storage words; any integer ≥ max(PAR_READ, PAR_WRITE), not restricted to a power of two
- PAR_WRITE, 4, maximum words written per cycle
- PAR_READ, 2, maximum words read per cycle
- AF_LEVEL, DEPTH-PAR_WRITE, almost_full asserted when count ≥ AF_LEVEL
- AE_LEVEL, PAR_READ, almost_empty asserted when count ≤ AE_LEVEL
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived)
- CNT_WIDTH, $clog2(DEPTH+1), occupancy width (derived)

Ports:

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents
- write_enable  in  1  write request
- wr_num  in  $clog2(PAR_WRITE+1)  words offered this cycle
- din  in  PAR_WRITE*DATA_WIDTH  lane i = din[i*DATA_WIDTH +: DATA_WIDTH]; lane 0 is written first
- read_enable  in  1  read request
- rd_num  in  $clog2(PAR_READ+1)  words consumed this cycle
- dout  out  PAR_READ*DATA_WIDTH  show-ahead head words; lane 0 is the oldest
- ready  out  1  free ≥ PAR_WRITE
- valid  out  1  count ≥ PAR_READ
- count  out  CNT_WIDTH  current occupancy
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation

- State: rptr and wptr (range 0..DEPTH-1), count (0..DEPTH), DEPTH×DATA_WIDTH storage, overflow and underflow flags. free = DEPTH − count.
- Write acceptance: wacc = write_enable & (wr_num ≤ free) & (wr_num ≤ PAR_WRITE), evaluated against the pre-edge count. On acceptance, lane i (i < wr_num) is stored at (wptr+i) mod DEPTH and wptr advances by wr_num mod DEPTH. A rejected write stores nothing and sets overflow.
- Read acceptance: racc = read_enable & (rd_num ≤ count) & (rd_num ≤ PAR_READ). On acceptance, rptr advances by rd_num mod DEPTH. A rejected read moves nothing and sets underflow.
- Simultaneous read and write are evaluated independently against the pre-edge state. Space freed by a same-cycle read is not available to that cycle's write. count_next = count + (wacc ? wr_num : 0) − (racc ? rd_num : 0).
- A request with a count of 0 is a no-op. It never flags an error.
- Modulo wrap is computed as a sum ≥ DEPTH, then subtract DEPTH. Intermediate sums use ADDR_WIDTH+1 bits. No reliance on power-of-two wrap.
- dout lane j = mem[(rptr+j) mod DEPTH] if j < count, otherwise all zeros. This path is combinational from registered state.
- flush, when high at an edge, forces rptr = wptr = count = 0 and ignores that cycle's read and write. flush does not clear overflow or underflow. Only rst clears them.
- Storage contents are not reset. Only pointers, count and flags are reset.

## Timing

- Reset (rst low, asynchronous): rptr = wptr = count = 0; ready = 1; valid = 0 (PAR_READ ≥ 1); almost_full = (AF_LEVEL == 0); almost_empty = 1; overflow = underflow = 0; dout = 0.
- Write-to-read latency: a word written at edge N appears on dout and in count immediately after edge N. Zero extra cycles; no bypass from din to dout in the same cycle.
- All flags are functions of registered count and update in the same cycle as count.
- Full boundary (count = DEPTH): ready = 0 and any wr_num ≥ 1 is rejected, even with a simultaneous read. Partial writes with wr_num ≤ free are still accepted when ready = 0.
- Empty boundary (count = 0): any rd_num ≥ 1 is rejected. dout is all zeros.
- Pointer wrap at DEPTH−1 → 0 is seamless across the lanes of a single multi-word write or read.

## Test plan

- Reset and fill: DEPTH=12, PAR_WRITE=4. Three writes of wr_num=4 with din lanes 0..11 → count 0→4→8→12. ready drops after the third write; almost_full rises at count 8; no overflow.
- Overflow: at count=12, write wr_num=1 plus a simultaneous read rd_num=2 → write rejected, overflow=1, count=10, dout advances by 2 words (lanes = 2,3 after the read).
- Wrap: wptr=10, write wr_num=4 of A,B,C,D → stored at 10,11,0,1. Drain with rd_num=2 reads → dout shows A,B then C,D.
- Mixed rates: each cycle write wr_num=3 and read rd_num=2 from empty → count rises by 1 per cycle (first read rejected with underflow=1). Data order is preserved end-to-end.
- Partial head: count=1, rd_num=2 → rejected, underflow=1, dout = {0, word}; count stays 1.
- Flush and async reset: flush with a pending write wr_num=4 → count=0, write dropped, sticky flags held. Drop rst mid-cycle → all outputs reach their reset values without waiting for a clock edge.
